// File: rtl/timer_pkg.sv
// Register map constants and field encodings shared by the multi-channel timer.
// No logic lives here; the top and the channel import it.
package timer_pkg;

    localparam logic [3:0]  OFF_COUNT    = 4'h0;
    localparam logic [3:0]  OFF_LOAD     = 4'h4;
    localparam logic [3:0]  OFF_CTRL     = 4'h8;
    localparam logic [3:0]  OFF_PRESC    = 4'hC;

    localparam logic [15:0] CH_STRIDE    = 16'h0010;
    localparam logic [15:0] STATUS_ADDR  = 16'h0100;
    localparam logic [15:0] PENDING_ADDR = 16'h0104;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_MODE = 2;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } timer_mode_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, down-counter, periodic reload / one-shot stop, expiry flag.
// Register writes land on the next clock edge; no backpressure, writes are always accepted.
module timer_channel
    import timer_pkg::*;
#(
    parameter int                 COUNT_W   = 16,
    parameter int                 PRESC_W   = 16,
    parameter logic [COUNT_W-1:0] LOAD_RST  = COUNT_W'(16'h000F),
    parameter logic [PRESC_W-1:0] PRESC_RST = PRESC_W'(16'h00FF),
    parameter bit                 AUTO_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_we,
    input  logic               ctrl_we,
    input  logic               presc_we,
    input  logic [COUNT_W-1:0] load_wdat,
    input  logic [2:0]         ctrl_wdat,
    input  logic [PRESC_W-1:0] presc_wdat,
    input  logic               flag_clr,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] load,
    output logic [PRESC_W-1:0] presc,
    output logic               en,
    output logic               ie,
    output logic               mode,
    output logic               flag
);

    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] load_q, load_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               en_q, en_d;
    logic               ie_q, ie_d;
    timer_mode_e        mode_q, mode_d;
    logic               flag_q, flag_d;
    logic               tick;
    logic               expire;

    always_comb begin
        count_d     = count_q;
        load_d      = load_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        en_d        = en_q;
        ie_d        = ie_q;
        mode_d      = mode_q;

        tick   = en_q && (presc_cnt_q == presc_q);
        expire = tick && (count_q == '0);

        if (en_q) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
        end
        if (tick) begin
            if (!expire) begin
                count_d = count_q - COUNT_W'(1);
            end else if (mode_q == MODE_PERIODIC) begin
                count_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (load_we) begin
            load_d = load_wdat;
        end
        if (presc_we) begin
            presc_d = presc_wdat;
        end
        // A software enable edge restarts the channel from LOAD, overriding this cycle's tick.
        if (ctrl_we) begin
            en_d   = ctrl_wdat[CTRL_EN];
            ie_d   = ctrl_wdat[CTRL_IE];
            mode_d = timer_mode_e'(ctrl_wdat[CTRL_MODE]);
            if (!en_q && ctrl_wdat[CTRL_EN]) begin
                count_d     = load_q;
                presc_cnt_d = '0;
            end
        end

        flag_d = expire | (flag_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= LOAD_RST;
            load_q      <= LOAD_RST;
            presc_q     <= PRESC_RST;
            presc_cnt_q <= '0;
            en_q        <= AUTO_EN;
            ie_q        <= AUTO_EN;
            mode_q      <= MODE_PERIODIC;
            flag_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            load_q      <= load_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            en_q        <= en_d;
            ie_q        <= ie_d;
            mode_q      <= mode_d;
            flag_q      <= flag_d;
        end
    end

    assign count = count_q;
    assign load  = load_q;
    assign presc = presc_q;
    assign en    = en_q;
    assign ie    = ie_q;
    assign mode  = (mode_q == MODE_ONESHOT);
    assign flag  = flag_q;

endmodule

// File: rtl/multi_timer_peripheral.sv
// Multi-channel timer on the peripheral register bus: decode, registered read mux, STATUS W1C, IRQ OR.
// Reads return data one cycle after the strobe; always ready, no backpressure.
module multi_timer_peripheral
    import timer_pkg::*;
#(
    parameter int                 NUM_CH    = 4,
    parameter int                 COUNT_W   = 16,
    parameter int                 PRESC_W   = 16,
    parameter logic [COUNT_W-1:0] LOAD_RST  = COUNT_W'(16'h000F),
    parameter logic [PRESC_W-1:0] PRESC_RST = PRESC_W'(16'h00FF),
    parameter bit                 AUTO_EN   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [15:0]               addr,
    input  logic [31:0]               data_in,
    output logic [31:0]               data_out,
    input  logic                      write_enable,
    input  logic                      read_enable,
    output logic                      interrupt,
    input  logic                      interrupt_ack,
    output logic                      ready,
    output logic [NUM_CH-1:0]         irq_flags,
    output logic [NUM_CH*COUNT_W-1:0] timer_count
);

    logic [COUNT_W-1:0] ch_count [NUM_CH];
    logic [COUNT_W-1:0] ch_load  [NUM_CH];
    logic [PRESC_W-1:0] ch_presc [NUM_CH];
    logic [NUM_CH-1:0]  ch_en;
    logic [NUM_CH-1:0]  ch_ie;
    logic [NUM_CH-1:0]  ch_mode;
    logic [NUM_CH-1:0]  ch_flag;
    logic [NUM_CH-1:0]  ch_hit;
    logic               status_we;
    logic [31:0]        rd_dat;
    logic [31:0]        data_out_q, data_out_d;
    logic               interrupt_q, interrupt_d;
    logic               unused_data;

    assign status_we   = write_enable && (addr == STATUS_ADDR);
    assign unused_data = ^data_in;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [15:0] CH_BASE = 16'(g) * CH_STRIDE;
        logic wr_hit;

        assign ch_hit[g] = ({addr[15:4], 4'h0} == CH_BASE);
        assign wr_hit    = write_enable && ch_hit[g];

        timer_channel #(
            .COUNT_W   (COUNT_W),
            .PRESC_W   (PRESC_W),
            .LOAD_RST  (LOAD_RST),
            .PRESC_RST (PRESC_RST),
            .AUTO_EN   (AUTO_EN)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .load_we    (wr_hit && (addr[3:0] == OFF_LOAD)),
            .ctrl_we    (wr_hit && (addr[3:0] == OFF_CTRL)),
            .presc_we   (wr_hit && (addr[3:0] == OFF_PRESC)),
            .load_wdat  (data_in[COUNT_W-1:0]),
            .ctrl_wdat  (data_in[2:0]),
            .presc_wdat (data_in[PRESC_W-1:0]),
            .flag_clr   (interrupt_ack | (status_we & data_in[g])),
            .count      (ch_count[g]),
            .load       (ch_load[g]),
            .presc      (ch_presc[g]),
            .en         (ch_en[g]),
            .ie         (ch_ie[g]),
            .mode       (ch_mode[g]),
            .flag       (ch_flag[g])
        );

        assign timer_count[g*COUNT_W +: COUNT_W] = ch_count[g];
    end

    // Read mux sees pre-write state, so a same-cycle write is not visible to the read.
    always_comb begin
        rd_dat = '0;
        if (addr == STATUS_ADDR) begin
            rd_dat = 32'(ch_flag);
        end else if (addr == PENDING_ADDR) begin
            rd_dat = 32'(ch_flag & ch_ie);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_hit[i]) begin
                    case (addr[3:0])
                        OFF_COUNT: rd_dat = 32'(ch_count[i]);
                        OFF_LOAD:  rd_dat = 32'(ch_load[i]);
                        OFF_CTRL: begin
                            rd_dat[CTRL_EN]   = ch_en[i];
                            rd_dat[CTRL_IE]   = ch_ie[i];
                            rd_dat[CTRL_MODE] = ch_mode[i];
                        end
                        OFF_PRESC: rd_dat = 32'(ch_presc[i]);
                        default:   rd_dat = '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        data_out_d  = read_enable ? rd_dat : '0;
        interrupt_d = |(ch_flag & ch_ie);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q  <= '0;
            interrupt_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign data_out  = data_out_q;
    assign interrupt = interrupt_q;
    assign ready     = 1'b1;
    assign irq_flags = ch_flag;

endmodule

// File: tb/tb_multi_timer_peripheral.sv
// Randomised register traffic against a behavioural model of the timer, plus directed scenarios.
module tb_multi_timer_peripheral;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int PW  = 16;
    localparam int unsigned CMASK = 32'h0000_FFFF;
    localparam int unsigned PMASK = 32'h0000_FFFF;
    localparam logic [15:0] ADDR_TAB [26] = '{
        16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0018, 16'h001C,
        16'h0020, 16'h0024, 16'h0028, 16'h002C, 16'h0030, 16'h0034, 16'h0038, 16'h003C,
        16'h0100, 16'h0104, 16'h0100, 16'h0104, 16'h0200, 16'h0204, 16'h0040, 16'h0048,
        16'h0002, 16'h0108
    };

    logic                clk = 1'b0;
    logic                reset_n;
    logic [15:0]         addr;
    logic [31:0]         data_in;
    logic [31:0]         data_out;
    logic                write_enable;
    logic                read_enable;
    logic                interrupt;
    logic                interrupt_ack;
    logic                ready;
    logic [NCH-1:0]      irq_flags;
    logic [NCH*CW-1:0]   timer_count;

    always #5 clk = ~clk;

    multi_timer_peripheral #(
        .NUM_CH    (NCH),
        .COUNT_W   (CW),
        .PRESC_W   (PW),
        .LOAD_RST  (16'h000F),
        .PRESC_RST (16'h00FF),
        .AUTO_EN   (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .addr          (addr),
        .data_in       (data_in),
        .data_out      (data_out),
        .write_enable  (write_enable),
        .read_enable   (read_enable),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .ready         (ready),
        .irq_flags     (irq_flags),
        .timer_count   (timer_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model state: what the registers should hold after the last modelled edge.
    int unsigned m_count [NCH];
    int unsigned m_load  [NCH];
    int unsigned m_presc [NCH];
    int unsigned m_pcnt  [NCH];
    bit          m_en    [NCH];
    bit          m_ie    [NCH];
    bit          m_mode  [NCH];
    bit          m_flag  [NCH];
    bit          m_irq;
    int unsigned m_dout;

    bit          pend_vld = 1'b0;
    int unsigned pend_val;
    string       pend_tag;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_count[c] = 15;
            m_load[c]  = 15;
            m_presc[c] = 255;
            m_pcnt[c]  = 0;
            m_en[c]    = 1;
            m_ie[c]    = 1;
            m_mode[c]  = 0;
            m_flag[c]  = 0;
        end
        m_irq  = 0;
        m_dout = 0;
    endtask

    function automatic int unsigned flags_word(input bit masked);
        int unsigned w = 0;
        for (int c = 0; c < NCH; c++)
            if (m_flag[c] && (!masked || m_ie[c])) w += (1 << c);
        return w;
    endfunction

    function automatic int unsigned model_read(input logic [15:0] a);
        int c;
        if (a == 16'h0100) return flags_word(1'b0);
        if (a == 16'h0104) return flags_word(1'b1);
        if (a[15:8] != 8'h00 || int'(a[7:4]) >= NCH) return 0;
        c = int'(a[7:4]);
        case (a[3:0])
            4'h0:    return m_count[c];
            4'h4:    return m_load[c];
            4'h8:    return 4 * int'(m_mode[c]) + 2 * int'(m_ie[c]) + int'(m_en[c]);
            4'hC:    return m_presc[c];
            default: return 0;
        endcase
    endfunction

    // Advance the model across one rising edge with the given bus inputs.
    task automatic model_step(input bit we, input bit re, input bit ack,
                              input logic [15:0] a, input logic [31:0] d);
        int unsigned rd = re ? model_read(a) : 0;
        bit irq_next = flags_word(1'b1) != 0;
        for (int c = 0; c < NCH; c++) begin
            bit          old_en   = m_en[c];
            int unsigned old_load = m_load[c];
            bit          tick     = m_en[c] && (m_pcnt[c] == m_presc[c]);
            bit          set      = 0;
            bit          clr      = ack || (we && a == 16'h0100 && d[c]);
            if (m_en[c]) m_pcnt[c] = tick ? 0 : (m_pcnt[c] + 1) & PMASK;
            if (tick) begin
                if (m_count[c] != 0) begin
                    m_count[c]--;
                end else begin
                    set = 1;
                    if (m_mode[c]) m_en[c] = 0;
                    else           m_count[c] = m_load[c];
                end
            end
            if (we && a[15:8] == 8'h00 && int'(a[7:4]) == c) begin
                case (a[3:0])
                    4'h4: m_load[c]  = d & CMASK;
                    4'hC: m_presc[c] = d & PMASK;
                    4'h8: begin
                        if (!old_en && d[0]) begin
                            m_count[c] = old_load;
                            m_pcnt[c]  = 0;
                        end
                        m_en[c]   = d[0];
                        m_ie[c]   = d[1];
                        m_mode[c] = d[2];
                    end
                    default: ;
                endcase
            end
            m_flag[c] = set || (m_flag[c] && !clr);
        end
        m_dout = rd;
        m_irq  = irq_next;
    endtask

    task automatic check_outputs();
        logic [NCH*CW-1:0] exp_cnt;
        for (int c = 0; c < NCH; c++) exp_cnt[c*CW +: CW] = CW'(m_count[c]);
        chk("data_out",    64'(data_out),    64'(m_dout));
        chk("interrupt",   64'(interrupt),   64'(m_irq));
        chk("irq_flags",   64'(irq_flags),   64'(flags_word(1'b0)));
        chk("timer_count", 64'(timer_count), 64'(exp_cnt));
        chk("ready",       64'(ready),       64'(1));
        if (pend_vld) begin
            chk(pend_tag, 64'(data_out), 64'(pend_val));
            pend_vld = 1'b0;
        end
    endtask

    task automatic cycle(input bit we, input bit re, input bit ack,
                         input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        check_outputs();
        write_enable  = we;
        read_enable   = re;
        interrupt_ack = ack;
        addr          = a;
        data_in       = d;
        model_step(we, re, ack, a, d);
    endtask

    task automatic idle_inputs();
        write_enable  = 0;
        read_enable   = 0;
        interrupt_ack = 0;
        addr          = '0;
        data_in       = '0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        model_reset();
        model_step(0, 0, 0, 16'h0, 32'h0);
    endtask

    task automatic expect_read(input string tag, input logic [15:0] a, input int unsigned v);
        cycle(0, 1, 0, a, 32'h0);
        pend_vld = 1'b1;
        pend_val = v;
        pend_tag = tag;
    endtask

    task automatic rand_cycle();
        int          r  = $urandom_range(0, 99);
        logic [15:0] a  = ADDR_TAB[$urandom_range(0, 25)];
        logic [31:0] d;
        if (a[15:8] == 8'h00 && a[3:0] == 4'h8)  d = 32'($urandom_range(0, 7));
        else if (a == 16'h0100)                  d = 32'($urandom_range(0, 15));
        else if ($urandom_range(0, 99) < 85)     d = 32'($urandom_range(0, 6));
        else                                     d = $urandom;
        if (r < 35)      cycle(1, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, a, d);
        else if (r < 70) cycle(0, 1, 0, a, d);
        else if (r < 73) cycle(0, 0, 1, a, d);
        else             cycle(0, 0, 0, a, d);
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        release_reset();

        // Reset defaults read back as constants.
        expect_read("rst_count0", 16'h0000, 32'h0000_000F);
        expect_read("rst_ctrl0",  16'h0008, 32'h0000_0003);
        expect_read("rst_presc0", 16'h000C, 32'h0000_00FF);
        cycle(0, 0, 0, 16'h0, 32'h0);

        // One-shot on ch2: LOAD=2, PRESCALE=1, then EN|IE|MODE.
        cycle(1, 0, 0, 16'h0028, 32'h0);
        cycle(1, 0, 0, 16'h0024, 32'h2);
        cycle(1, 0, 0, 16'h002C, 32'h1);
        cycle(1, 0, 0, 16'h0028, 32'h7);
        repeat (10) cycle(0, 0, 0, 16'h0, 32'h0);
        expect_read("oneshot_ctrl2",  16'h0028, 32'h0000_0006);
        expect_read("oneshot_count2", 16'h0020, 32'h0000_0000);
        expect_read("decode_0200",    16'h0200, 32'h0000_0000);
        cycle(1, 0, 1, 16'h0204, 32'hFFFF_FFFF);

        for (int i = 0; i < 3000; i++) rand_cycle();

        // Async reset while ch1 counts down from 3 with no prescaling.
        cycle(1, 0, 0, 16'h0018, 32'h0);
        cycle(1, 0, 0, 16'h0014, 32'h3);
        cycle(1, 0, 0, 16'h001C, 32'h0);
        cycle(1, 0, 0, 16'h0018, 32'h3);
        for (int i = 0; i < 20 && m_count[1] != 2; i++) cycle(0, 0, 0, 16'h0, 32'h0);
        chk("ch1_reached_2", 64'(m_count[1]), 64'(2));
        @(negedge clk);
        check_outputs();
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", 64'(timer_count), 64'h000F_000F_000F_000F);
        chk("arst_flags", 64'(irq_flags),   64'(0));
        chk("arst_irq",   64'(interrupt),   64'(0));
        chk("arst_dout",  64'(data_out),    64'(0));
        repeat (2) @(negedge clk);
        release_reset();
        for (int i = 0; i < 200; i++) rand_cycle();
        cycle(0, 0, 0, 16'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
